// File: rtl/lc3_pkg.sv
// Shared constants, types and condition-code helper for the LC-3 register bank.
package lc3_pkg;

    localparam int unsigned DATA_W    = 16;
    localparam int unsigned REG_IDX_W = 3;
    localparam int unsigned NUM_REGS  = 8;

    localparam logic [2:0] CC_N     = 3'b100;
    localparam logic [2:0] CC_Z     = 3'b010;
    localparam logic [2:0] CC_P     = 3'b001;
    localparam logic [2:0] CC_RESET = CC_Z;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    // Always one-hot: sign bit wins, then zero, else positive.
    function automatic logic [2:0] nzp_of(input logic [DATA_W-1:0] value);
        if (value[DATA_W-1]) begin
            return CC_N;
        end else if (value == '0) begin
            return CC_Z;
        end
        return CC_P;
    endfunction

endpackage

// File: rtl/lc3_reg_bank_if.sv
// Datapath-facing signal bundle of the LC-3 register bank.
interface lc3_reg_bank_if #(
    parameter int unsigned DATA_W = lc3_pkg::DATA_W
);
    logic              ld_reg;
    logic [2:0]        dr;
    logic [DATA_W-1:0] bus_in;
    logic              ld_cc;
    logic [2:0]        sr1;
    logic [2:0]        sr2;
    logic [DATA_W-1:0] sr1_out;
    logic [DATA_W-1:0] sr2_out;
    logic              n;
    logic              z;
    logic              p;

    modport master (
        output ld_reg, dr, bus_in, ld_cc, sr1, sr2,
        input  sr1_out, sr2_out, n, z, p
    );

    modport slave (
        input  ld_reg, dr, bus_in, ld_cc, sr1, sr2,
        output sr1_out, sr2_out, n, z, p
    );
endinterface

// File: rtl/reg_read_port.sv
// Combinational 8:1 selector returning one register of the bank.
module reg_read_port
    import lc3_pkg::*;
#(
    parameter int unsigned DATA_W = lc3_pkg::DATA_W
) (
    input  logic [NUM_REGS-1:0][DATA_W-1:0] regs_i,
    input  reg_idx_t                        sel_i,
    output logic [DATA_W-1:0]               data_o
);

    assign data_o = regs_i[sel_i];

endmodule

// File: rtl/lc3_reg_bank.sv
// LC-3 R0-R7 register bank with NZP condition codes.
// Optional write-through forwarding when LC3_REGBANK_BYPASS_EN is defined.
module lc3_reg_bank
    import lc3_pkg::*;
#(
    parameter int unsigned DATA_W   = lc3_pkg::DATA_W,
    parameter logic [2:0]  CC_RESET = lc3_pkg::CC_RESET
) (
    input  logic          clk,
    input  logic          rst,
    lc3_reg_bank_if.slave rb
);

    logic [NUM_REGS-1:0][DATA_W-1:0] regs_q, regs_d;
    logic [2:0]                      nzp_q, nzp_d;
    logic [DATA_W-1:0]               rd1, rd2;

    always_comb begin
        regs_d = regs_q;
        nzp_d  = nzp_q;
        if (rb.ld_reg) begin
            regs_d[rb.dr] = rb.bus_in;
        end
        if (rb.ld_cc) begin
            nzp_d = nzp_of(rb.bus_in);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs_q <= '0;
            nzp_q  <= CC_RESET;
        end else begin
            regs_q <= regs_d;
            nzp_q  <= nzp_d;
        end
    end

    reg_read_port #(
        .DATA_W (DATA_W)
    ) u_rd1 (
        .regs_i (regs_q),
        .sel_i  (rb.sr1),
        .data_o (rd1)
    );

    reg_read_port #(
        .DATA_W (DATA_W)
    ) u_rd2 (
        .regs_i (regs_q),
        .sel_i  (rb.sr2),
        .data_o (rd2)
    );

`ifdef LC3_REGBANK_BYPASS_EN
    // Forward the bus value into a reader of the register being written this cycle.
    assign rb.sr1_out = (rb.ld_reg && !rst && (rb.sr1 == rb.dr)) ? rb.bus_in : rd1;
    assign rb.sr2_out = (rb.ld_reg && !rst && (rb.sr2 == rb.dr)) ? rb.bus_in : rd2;
`else
    assign rb.sr1_out = rd1;
    assign rb.sr2_out = rd2;
`endif

    assign {rb.n, rb.z, rb.p} = nzp_q;

endmodule
